proc_hier: RTL and testbench
============================

# proc_hier

Top-level processor-hierarchy monitor. It sits beside the core and samples the core's commit-stage and cache event signals each cycle. It maintains the cycle, instruction and cache hit/request statistics and latches halt. It emits a registered, one-record-per-cycle trace of register writes, loads and stores for the simulation log.

## Interface
- `CNT_W`, default 32: width of every statistics counter.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pc_i` in 16: fetch PC.
- `inst_i` in 16: instruction in the fetch/decode register.
- `reg_write_i` in 1: register file written this cycle.
- `write_reg_i` in 3: destination register.
- `write_data_i` in 16: write-back data.
- `mem_read_i`, `mem_write_i` in 1 each: data-memory access completes this cycle.
- `mem_addr_i` in 16: data-memory address.
- `mem_data_in_i` in 16: store data.
- `mem_data_out_i` in 16: load data.
- `icache_req_i`, `icache_hit_i`, `dcache_req_i`, `dcache_hit_i` in 1 each: cache request-done and hit strobes.
- `halt_i` in 1: halt instruction retiring.
- `cycle_count_o`, `inst_count_o` out CNT_W each.
- `icache_req_count_o`, `icache_hit_count_o`, `dcache_req_count_o`, `dcache_hit_count_o` out CNT_W each.
- `halted_o` out 1.
- `proto_err_o` out 1: sticky protocol error.
- `trc_pc_o`, `trc_inst_o` out 16.
- `trc_reg_valid_o` out 1, `trc_reg_sel_o` out 3, `trc_reg_data_o` out 16.
- `trc_load_valid_o`, `trc_store_valid_o` out 1 each.
- `trc_mem_addr_o`, `trc_mem_data_o` out 16 each.

## Operation
- An active cycle is any rising edge with `rst` high and `halted_o` low. Nothing updates in a non-active cycle except reset.
- `cycle_count_o` increments by 1 in every active cycle.
- `inst_count_o` increments when `halt_i | reg_write_i | mem_write_i`. The halt cycle itself counts.
- Each cache counter increments when its strobe is high. Counters are independent, so hit and req may both increment in one cycle.
- All counters wrap modulo 2^CNT_W.
- `halted_o` sets on the active cycle with `halt_i`=1 and stays set until reset. All counters and the trace freeze from then on.
- `proto_err_o` is sticky. It sets on an active cycle with any of:
  - `icache_hit_i & ~icache_req_i`
  - `dcache_hit_i & ~dcache_req_i`
  - `mem_read_i & mem_write_i`
- Trace (registered, every active cycle):
  - `trc_pc_o`, `trc_inst_o` capture `pc_i`, `inst_i`.
  - `trc_reg_valid_o` = `reg_write_i`, with sel/data captured.
  - `trc_store_valid_o` = `mem_write_i`. `trc_load_valid_o` = `mem_read_i & ~mem_write_i`, so a store wins on collision.
  - `trc_mem_addr_o` = `mem_addr_i`. `trc_mem_data_o` = `mem_data_in_i` for a store, else `mem_data_out_i`.
- In a non-active cycle all trace valids drop to 0; trace data holds.

## Timing
- Reset (`rst`=0, asynchronous): every output is 0.
- All outputs are registered with 1-cycle latency: an input sampled at edge N is visible after edge N.
- Reset released mid-run: the first active edge is the first edge with `rst` high, and `cycle_count_o` reads 1 after it.
- Reset asserted while halted: `halted_o` and all counters clear immediately.
- After the halt edge, `inst_count_o` includes the halt and `cycle_count_o` includes the halt cycle. Both then hold indefinitely.

## Structure
- Package `proc_hier_pkg`: `CNT_W` default, the 16-bit word and 3-bit regsel typedefs, and a trace-kind enum (NONE/LOAD/STORE).
- Sub-module `event_counter` (params `W`; ports clk, rst, en, clr-free, count). Instantiate it 6 times with enable = active & event.
- Trace register and halt/error flags live in the top level.

## Test plan
- Reset then 5 idle active cycles: `cycle_count_o`=5, all other counters 0, all trace valids 0.
- `reg_write_i`=1, reg 3, data 0x1234, one cycle: next cycle `trc_reg_valid_o`=1, sel 3, data 0x1234; `inst_count_o`=1.
- Store at 0x0040 with data 0xBEEF, then a load at 0x0040 returning 0xBEEF: store record valid, then load record valid. Address 0x0040 and data 0xBEEF in both. `inst_count_o` +1 for the store only.
- icache req+hit for 3 cycles, then req-only for 2: `icache_req_count_o`=5, `icache_hit_count_o`=3, `proto_err_o`=0. Then hit without req: `proto_err_o`=1 and it stays 1.
- `halt_i` at cycle 10, inputs keep toggling afterwards: `halted_o`=1, `cycle_count_o`=10, and the halt is included in the instruction count. All values frozen 20 cycles later. Asserting `rst`=0 clears everything without waiting for a clock.
- CNT_W=4: 17 instruction cycles → `inst_count_o`=1 (wrap).

Source files
------------

// File: rtl/proc_hier_pkg.sv
// Shared types and defaults for the processor-hierarchy monitor.
// Trace-record classification lives here so the top and any log tooling agree on it.
package proc_hier_pkg;

    localparam int unsigned CNT_W_DEF = 32;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  regsel_t;

    typedef enum logic [1:0] {
        TRC_NONE  = 2'd0,
        TRC_LOAD  = 2'd1,
        TRC_STORE = 2'd2
    } trc_kind_e;

    // A store wins when both memory strobes collide.
    function automatic trc_kind_e trc_kind(input logic rd, input logic wr);
        if (wr) begin
            return TRC_STORE;
        end
        if (rd) begin
            return TRC_LOAD;
        end
        return TRC_NONE;
    endfunction

endpackage

// File: rtl/event_counter.sv
// Free-running wrap-around event counter with enable; cleared only by async reset.
module event_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/proc_hier.sv
// Processor-hierarchy monitor: statistics counters, halt/protocol flags and a
// registered one-record-per-cycle commit trace. Everything freezes once halted.
module proc_hier
    import proc_hier_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      pc_i,
    input  logic [15:0]      inst_i,
    input  logic             reg_write_i,
    input  logic [2:0]       write_reg_i,
    input  logic [15:0]      write_data_i,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    input  logic [15:0]      mem_addr_i,
    input  logic [15:0]      mem_data_in_i,
    input  logic [15:0]      mem_data_out_i,
    input  logic             icache_req_i,
    input  logic             icache_hit_i,
    input  logic             dcache_req_i,
    input  logic             dcache_hit_i,
    input  logic             halt_i,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [CNT_W-1:0] inst_count_o,
    output logic [CNT_W-1:0] icache_req_count_o,
    output logic [CNT_W-1:0] icache_hit_count_o,
    output logic [CNT_W-1:0] dcache_req_count_o,
    output logic [CNT_W-1:0] dcache_hit_count_o,
    output logic             halted_o,
    output logic             proto_err_o,
    output logic [15:0]      trc_pc_o,
    output logic [15:0]      trc_inst_o,
    output logic             trc_reg_valid_o,
    output logic [2:0]       trc_reg_sel_o,
    output logic [15:0]      trc_reg_data_o,
    output logic             trc_load_valid_o,
    output logic             trc_store_valid_o,
    output logic [15:0]      trc_mem_addr_o,
    output logic [15:0]      trc_mem_data_o
);

    localparam int unsigned N_CNT = 6;

    logic halted_q, halted_d;
    logic err_q, err_d;
    logic active;
    logic proto_viol;

    assign active     = ~halted_q;
    assign proto_viol = (icache_hit_i & ~icache_req_i)
                      | (dcache_hit_i & ~dcache_req_i)
                      | (mem_read_i & mem_write_i);

    // Counter order: cycle, inst, icache req, icache hit, dcache req, dcache hit.
    logic [N_CNT-1:0] cnt_ev;
    logic [CNT_W-1:0] cnt_val [N_CNT];

    assign cnt_ev = {dcache_hit_i, dcache_req_i, icache_hit_i, icache_req_i,
                     halt_i | reg_write_i | mem_write_i, 1'b1};

    for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
        event_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .en    (active & cnt_ev[g]),
            .count (cnt_val[g])
        );
    end

    assign cycle_count_o      = cnt_val[0];
    assign inst_count_o       = cnt_val[1];
    assign icache_req_count_o = cnt_val[2];
    assign icache_hit_count_o = cnt_val[3];
    assign dcache_req_count_o = cnt_val[4];
    assign dcache_hit_count_o = cnt_val[5];

    word_t     pc_q, pc_d, inst_q, inst_d;
    logic      reg_vld_q, reg_vld_d;
    regsel_t   reg_sel_q, reg_sel_d;
    word_t     reg_data_q, reg_data_d;
    trc_kind_e kind_q, kind_d;
    word_t     maddr_q, maddr_d, mdata_q, mdata_d;

    always_comb begin
        halted_d   = halted_q | (active & halt_i);
        err_d      = err_q | (active & proto_viol);
        pc_d       = pc_q;
        inst_d     = inst_q;
        reg_vld_d  = 1'b0;
        reg_sel_d  = reg_sel_q;
        reg_data_d = reg_data_q;
        kind_d     = TRC_NONE;
        maddr_d    = maddr_q;
        mdata_d    = mdata_q;
        if (active) begin
            pc_d       = pc_i;
            inst_d     = inst_i;
            reg_vld_d  = reg_write_i;
            reg_sel_d  = write_reg_i;
            reg_data_d = write_data_i;
            kind_d     = trc_kind(mem_read_i, mem_write_i);
            maddr_d    = mem_addr_i;
            mdata_d    = mem_write_i ? mem_data_in_i : mem_data_out_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
            pc_q       <= '0;
            inst_q     <= '0;
            reg_vld_q  <= 1'b0;
            reg_sel_q  <= '0;
            reg_data_q <= '0;
            kind_q     <= TRC_NONE;
            maddr_q    <= '0;
            mdata_q    <= '0;
        end else begin
            halted_q   <= halted_d;
            err_q      <= err_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            reg_vld_q  <= reg_vld_d;
            reg_sel_q  <= reg_sel_d;
            reg_data_q <= reg_data_d;
            kind_q     <= kind_d;
            maddr_q    <= maddr_d;
            mdata_q    <= mdata_d;
        end
    end

    assign halted_o          = halted_q;
    assign proto_err_o       = err_q;
    assign trc_pc_o          = pc_q;
    assign trc_inst_o        = inst_q;
    assign trc_reg_valid_o   = reg_vld_q;
    assign trc_reg_sel_o     = reg_sel_q;
    assign trc_reg_data_o    = reg_data_q;
    assign trc_load_valid_o  = (kind_q == TRC_LOAD);
    assign trc_store_valid_o = (kind_q == TRC_STORE);
    assign trc_mem_addr_o    = maddr_q;
    assign trc_mem_data_o    = mdata_q;

endmodule

// File: tb/tb_proc_hier.sv
// Randomized self-checking bench for proc_hier against a per-edge behavioural model;
// a second instance with 4-bit counters exercises wrap-around on the same stimulus.
module tb_proc_hier;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pc_i = '0, inst_i = '0, write_data_i = '0;
    logic        reg_write_i = 1'b0;
    logic [2:0]  write_reg_i = '0;
    logic        mem_read_i = 1'b0, mem_write_i = 1'b0;
    logic [15:0] mem_addr_i = '0, mem_data_in_i = '0, mem_data_out_i = '0;
    logic        icache_req_i = 1'b0, icache_hit_i = 1'b0;
    logic        dcache_req_i = 1'b0, dcache_hit_i = 1'b0;
    logic        halt_i = 1'b0;

    logic [31:0] c32 [6];
    logic [3:0]  c4 [6];
    logic        halted_o, proto_err_o, trc_reg_valid_o, trc_load_valid_o, trc_store_valid_o;
    logic [15:0] trc_pc_o, trc_inst_o, trc_reg_data_o, trc_mem_addr_o, trc_mem_data_o;
    logic [2:0]  trc_reg_sel_o;
    logic        w4_halted, w4_err, w4_rv, w4_lv, w4_sv;
    logic [15:0] w4_pc, w4_inst, w4_rd, w4_ma, w4_md;
    logic [2:0]  w4_rs;

    always #5 clk = ~clk;

    proc_hier u_dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i),
        .reg_write_i(reg_write_i), .write_reg_i(write_reg_i), .write_data_i(write_data_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_addr_i(mem_addr_i),
        .mem_data_in_i(mem_data_in_i), .mem_data_out_i(mem_data_out_i),
        .icache_req_i(icache_req_i), .icache_hit_i(icache_hit_i),
        .dcache_req_i(dcache_req_i), .dcache_hit_i(dcache_hit_i), .halt_i(halt_i),
        .cycle_count_o(c32[0]), .inst_count_o(c32[1]),
        .icache_req_count_o(c32[2]), .icache_hit_count_o(c32[3]),
        .dcache_req_count_o(c32[4]), .dcache_hit_count_o(c32[5]),
        .halted_o(halted_o), .proto_err_o(proto_err_o),
        .trc_pc_o(trc_pc_o), .trc_inst_o(trc_inst_o),
        .trc_reg_valid_o(trc_reg_valid_o), .trc_reg_sel_o(trc_reg_sel_o),
        .trc_reg_data_o(trc_reg_data_o), .trc_load_valid_o(trc_load_valid_o),
        .trc_store_valid_o(trc_store_valid_o), .trc_mem_addr_o(trc_mem_addr_o),
        .trc_mem_data_o(trc_mem_data_o)
    );

    proc_hier #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i),
        .reg_write_i(reg_write_i), .write_reg_i(write_reg_i), .write_data_i(write_data_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_addr_i(mem_addr_i),
        .mem_data_in_i(mem_data_in_i), .mem_data_out_i(mem_data_out_i),
        .icache_req_i(icache_req_i), .icache_hit_i(icache_hit_i),
        .dcache_req_i(dcache_req_i), .dcache_hit_i(dcache_hit_i), .halt_i(halt_i),
        .cycle_count_o(c4[0]), .inst_count_o(c4[1]),
        .icache_req_count_o(c4[2]), .icache_hit_count_o(c4[3]),
        .dcache_req_count_o(c4[4]), .dcache_hit_count_o(c4[5]),
        .halted_o(w4_halted), .proto_err_o(w4_err),
        .trc_pc_o(w4_pc), .trc_inst_o(w4_inst),
        .trc_reg_valid_o(w4_rv), .trc_reg_sel_o(w4_rs),
        .trc_reg_data_o(w4_rd), .trc_load_valid_o(w4_lv),
        .trc_store_valid_o(w4_sv), .trc_mem_addr_o(w4_ma),
        .trc_mem_data_o(w4_md)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: unbounded counts reduced modulo the counter width when compared.
    longint unsigned m_cnt [6];
    bit              m_halted, m_err, m_rv, m_lv, m_sv;
    logic [15:0]     m_pc, m_inst, m_rd, m_ma, m_md;
    logic [2:0]      m_rs;
    string           cnt_name [6] = '{"cycle", "inst", "ireq", "ihit", "dreq", "dhit"};

    function automatic void model_reset();
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_halted = 0; m_err = 0; m_rv = 0; m_lv = 0; m_sv = 0;
        m_pc = '0; m_inst = '0; m_rd = '0; m_ma = '0; m_md = '0; m_rs = '0;
    endfunction

    function automatic void model_edge();
        if (!rst) begin
            model_reset();
        end else if (m_halted) begin
            m_rv = 0; m_lv = 0; m_sv = 0;
        end else begin
            m_cnt[0] += 1;
            if (halt_i || reg_write_i || mem_write_i) m_cnt[1] += 1;
            if (icache_req_i) m_cnt[2] += 1;
            if (icache_hit_i) m_cnt[3] += 1;
            if (dcache_req_i) m_cnt[4] += 1;
            if (dcache_hit_i) m_cnt[5] += 1;
            if ((icache_hit_i && !icache_req_i) || (dcache_hit_i && !dcache_req_i) ||
                (mem_read_i && mem_write_i)) m_err = 1;
            m_pc = pc_i; m_inst = inst_i;
            m_rv = reg_write_i; m_rs = write_reg_i; m_rd = write_data_i;
            m_sv = mem_write_i; m_lv = mem_read_i && !mem_write_i;
            m_ma = mem_addr_i;
            m_md = mem_write_i ? mem_data_in_i : mem_data_out_i;
            if (halt_i) m_halted = 1;
        end
    endfunction

    task automatic check_all();
        for (int k = 0; k < 6; k++) begin
            check(cnt_name[k], 64'(c32[k]), m_cnt[k] & 64'hFFFF_FFFF);
            check({cnt_name[k], "_w4"}, 64'(c4[k]), m_cnt[k] & 64'hF);
        end
        check("halted", 64'(halted_o), 64'(m_halted));
        check("halted_w4", 64'(w4_halted), 64'(m_halted));
        check("proto_err", 64'(proto_err_o), 64'(m_err));
        check("trc_pc", 64'(trc_pc_o), 64'(m_pc));
        check("trc_inst", 64'(trc_inst_o), 64'(m_inst));
        check("trc_reg_valid", 64'(trc_reg_valid_o), 64'(m_rv));
        check("trc_reg_sel", 64'(trc_reg_sel_o), 64'(m_rs));
        check("trc_reg_data", 64'(trc_reg_data_o), 64'(m_rd));
        check("trc_load_valid", 64'(trc_load_valid_o), 64'(m_lv));
        check("trc_store_valid", 64'(trc_store_valid_o), 64'(m_sv));
        check("trc_mem_addr", 64'(trc_mem_addr_o), 64'(m_ma));
        check("trc_mem_data", 64'(trc_mem_data_o), 64'(m_md));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive_idle();
        reg_write_i = 0; mem_read_i = 0; mem_write_i = 0; halt_i = 0;
        icache_req_i = 0; icache_hit_i = 0; dcache_req_i = 0; dcache_hit_i = 0;
    endtask

    task automatic drive_rand(input bit allow_halt);
        pc_i = 16'($urandom); inst_i = 16'($urandom);
        reg_write_i = 1'($urandom); write_reg_i = 3'($urandom); write_data_i = 16'($urandom);
        mem_write_i = ($urandom_range(0, 3) == 0);
        mem_read_i  = mem_write_i ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
        mem_addr_i = 16'($urandom); mem_data_in_i = 16'($urandom); mem_data_out_i = 16'($urandom);
        icache_req_i = 1'($urandom);
        icache_hit_i = icache_req_i ? 1'($urandom) : ($urandom_range(0, 31) == 0);
        dcache_req_i = 1'($urandom);
        dcache_hit_i = dcache_req_i ? 1'($urandom) : ($urandom_range(0, 31) == 0);
        halt_i = allow_halt && ($urandom_range(0, 39) == 0);
    endtask

    // Asynchronous reset pulse, checked before any clock edge, released after one edge.
    task automatic do_reset();
        rst = 0;
        model_reset();
        #1;
        check_all();
        cycle();
        rst = 1;
    endtask

    longint unsigned inst_before;

    initial begin
        model_reset();
        #2;
        check_all();
        @(posedge clk); #1;
        check_all();
        rst = 1;

        drive_idle();
        repeat (5) cycle();
        check("idle5_cycle", 64'(c32[0]), 64'd5);
        check("idle5_inst", 64'(c32[1]), 64'd0);

        reg_write_i = 1; write_reg_i = 3'd3; write_data_i = 16'h1234;
        cycle();
        drive_idle();
        check("rw_valid", 64'(trc_reg_valid_o), 64'd1);
        check("rw_sel", 64'(trc_reg_sel_o), 64'd3);
        check("rw_data", 64'(trc_reg_data_o), 64'h1234);
        check("rw_inst", 64'(c32[1]), 64'd1);

        inst_before = m_cnt[1];
        mem_write_i = 1; mem_addr_i = 16'h0040; mem_data_in_i = 16'hBEEF; mem_data_out_i = 16'h5555;
        cycle();
        check("st_valid", 64'(trc_store_valid_o), 64'd1);
        check("st_ld_valid", 64'(trc_load_valid_o), 64'd0);
        check("st_data", 64'(trc_mem_data_o), 64'hBEEF);
        check("st_inst", 64'(c32[1]), inst_before + 1);
        mem_write_i = 0; mem_read_i = 1; mem_data_in_i = 16'h0000; mem_data_out_i = 16'hBEEF;
        cycle();
        mem_read_i = 0;
        check("ld_valid", 64'(trc_load_valid_o), 64'd1);
        check("ld_addr", 64'(trc_mem_addr_o), 64'h0040);
        check("ld_data", 64'(trc_mem_data_o), 64'hBEEF);
        check("ld_inst", 64'(c32[1]), inst_before + 1);

        do_reset();
        drive_idle();
        icache_req_i = 1; icache_hit_i = 1;
        repeat (3) cycle();
        icache_hit_i = 0;
        repeat (2) cycle();
        check("ic_req", 64'(c32[2]), 64'd5);
        check("ic_hit", 64'(c32[3]), 64'd3);
        check("ic_err0", 64'(proto_err_o), 64'd0);
        icache_req_i = 0; icache_hit_i = 1;
        cycle();
        check("ic_err1", 64'(proto_err_o), 64'd1);
        drive_idle();
        repeat (3) cycle();
        check("ic_err_sticky", 64'(proto_err_o), 64'd1);

        do_reset();
        repeat (9) begin drive_rand(0); cycle(); end
        drive_rand(0); halt_i = 1;
        cycle();
        check("halt_flag", 64'(halted_o), 64'd1);
        check("halt_cycle", 64'(c32[0]), 64'd10);
        repeat (20) begin drive_rand(1); cycle(); end
        check("frozen_cycle", 64'(c32[0]), 64'd10);
        check("frozen_halted", 64'(halted_o), 64'd1);
        #3;
        do_reset();

        drive_idle();
        reg_write_i = 1;
        repeat (17) cycle();
        check("wrap_inst_w4", 64'(c4[1]), 64'd1);
        check("wrap_inst_w32", 64'(c32[1]), 64'd17);
        drive_idle();

        for (int i = 0; i < 800; i++) begin
            drive_rand(1);
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                cycle();
            end
            if (m_halted && $urandom_range(0, 9) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
